// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and controller state encoding.
// The IV is shared with the datapath so both sides agree on the initial hash value.
package sha256_pkg;

    localparam int MSG_WORDS = 16;
    localparam int ROUNDS    = 64;

    // H0 in the top word down to H7 in the bottom word.
    localparam logic [255:0] IV_ALL = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/sha256_msg_buf.sv
// 16x32 message word store: one synchronous write port, one combinational read port.
// Contents are never reset; every hash overwrites all sixteen words before they are read.
module sha256_msg_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] word_q [MSG_WORDS];

    generate
        for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (we && (waddr == 4'(gi))) begin
                    word_reg <= wdata;
                end
            end
            assign word_q[gi] = word_reg;
        end
    endgenerate

    assign rdata = word_q[raddr];

endmodule

// File: rtl/sha256_ctrl.sv
// Single-block SHA-256 sequencer: collects 16 words, steps an external round datapath
// through 64 rounds, then adds the IV to the working registers to form the digest.
module sha256_ctrl
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         msg_valid,
    input  logic [31:0]  msg_word,
    output logic         msg_ready,
    output logic         dp_init,
    output logic [5:0]   dp_round_idx,
    output logic [31:0]  dp_message,
    input  logic [31:0]  dp_a,
    input  logic [31:0]  dp_b,
    input  logic [31:0]  dp_c,
    input  logic [31:0]  dp_d,
    input  logic [31:0]  dp_e,
    input  logic [31:0]  dp_f,
    input  logic [31:0]  dp_g,
    input  logic [31:0]  dp_h,
    output logic         busy,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
);

    state_t        state_reg, state_next;
    logic [3:0]    wcnt_reg, wcnt_next;
    logic [5:0]    round_reg, round_next;
    logic [255:0]  digest_reg, digest_next;
    logic [255:0]  digest_sum;
    logic          buf_we;
    logic [31:0]   buf_rdata;
    logic [31:0]   dp_words [8];

    sha256_msg_buf u_msg_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wcnt_reg),
        .wdata (msg_word),
        .raddr (round_reg[3:0]),
        .rdata (buf_rdata)
    );

    assign dp_words[0] = dp_a;
    assign dp_words[1] = dp_b;
    assign dp_words[2] = dp_c;
    assign dp_words[3] = dp_d;
    assign dp_words[4] = dp_e;
    assign dp_words[5] = dp_f;
    assign dp_words[6] = dp_g;
    assign dp_words[7] = dp_h;

    // Working register a..h folds into H0..H7, each sum wrapping at 32 bits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sum
            assign digest_sum[(7-gi)*32 +: 32] = IV_ALL[(7-gi)*32 +: 32] + dp_words[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_LOAD;
            wcnt_reg   <= 4'd0;
            round_reg  <= 6'd0;
            digest_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wcnt_reg   <= wcnt_next;
            round_reg  <= round_next;
            digest_reg <= digest_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wcnt_next    = wcnt_reg;
        round_next   = round_reg;
        digest_next  = digest_reg;
        buf_we       = 1'b0;
        msg_ready    = 1'b0;
        dp_init      = 1'b1;
        dp_round_idx = 6'd0;
        dp_message   = 32'd0;
        busy         = 1'b0;
        digest_valid = 1'b0;

        case (state_reg)
            ST_LOAD: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    buf_we    = 1'b1;
                    wcnt_next = wcnt_reg + 4'd1;
                    if (wcnt_reg == 4'd15) begin
                        state_next = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                dp_init      = 1'b0;
                busy         = 1'b1;
                dp_round_idx = round_reg;
                if (round_reg < 6'd16) begin
                    dp_message = buf_rdata;
                end
                // Counter wraps to 0 on its own after round 63.
                round_next = round_reg + 6'd1;
                if (round_reg == 6'd63) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                busy        = 1'b1;
                digest_next = digest_sum;
                state_next  = ST_OUT;
            end
            ST_OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase

        // Abort overrides everything, including a word write in the same cycle.
        if (clear) begin
            state_next  = ST_LOAD;
            wcnt_next   = 4'd0;
            round_next  = 6'd0;
            buf_we      = 1'b0;
            digest_next = digest_reg;
        end
    end

    assign digest = digest_reg;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Bench for sha256_ctrl: a behavioural SHA-256 round datapath closes the loop,
// and digests are compared against published test vectors.
module tb_sha256_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         msg_valid;
    logic [31:0]  msg_word;
    logic         msg_ready;
    logic         dp_init;
    logic [5:0]   dp_round_idx;
    logic [31:0]  dp_message;
    logic [31:0]  ra, rb, rc, rd, re, rf, rg, rh;
    logic         busy;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest;

    always #5 clk = ~clk;

    sha256_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .msg_valid    (msg_valid),
        .msg_word     (msg_word),
        .msg_ready    (msg_ready),
        .dp_init      (dp_init),
        .dp_round_idx (dp_round_idx),
        .dp_message   (dp_message),
        .dp_a         (ra),
        .dp_b         (rb),
        .dp_c         (rc),
        .dp_d         (rd),
        .dp_e         (re),
        .dp_f         (rf),
        .dp_g         (rg),
        .dp_h         (rh),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest)
    );

    // ---------------- behavioural round datapath ----------------
    localparam logic [255:0] TB_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

    logic [31:0] kt [64];
    logic [31:0] wwin [16];
    logic [31:0] wt, t1, t2;

    initial begin
        kt = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        wt = 32'd0;
        if (dp_round_idx < 6'd16) begin
            wt = dp_message;
        end else begin
            wt = (rotr(wwin[14], 17) ^ rotr(wwin[14], 19) ^ (wwin[14] >> 10)) + wwin[9]
               + (rotr(wwin[1], 7) ^ rotr(wwin[1], 18) ^ (wwin[1] >> 3)) + wwin[0];
        end
        t1 = rh + (rotr(re, 6) ^ rotr(re, 11) ^ rotr(re, 25)) + ((re & rf) ^ (~re & rg))
           + kt[dp_round_idx] + wt;
        t2 = (rotr(ra, 2) ^ rotr(ra, 13) ^ rotr(ra, 22)) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
    end

    always @(posedge clk) begin
        if (dp_init) begin
            ra <= TB_IV[255:224]; rb <= TB_IV[223:192]; rc <= TB_IV[191:160]; rd <= TB_IV[159:128];
            re <= TB_IV[127:96];  rf <= TB_IV[95:64];   rg <= TB_IV[63:32];   rh <= TB_IV[31:0];
        end else begin
            ra <= t1 + t2; rb <= ra; rc <= rb; rd <= rc;
            re <= rd + t1; rf <= re; rg <= rf; rh <= rg;
            for (int i = 0; i < 15; i++) wwin[i] <= wwin[i + 1];
            wwin[15] <= wt;
        end
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [255:0] exp;
        int           gaps;
        int           hold;
    } vec_t;

    vec_t vecs [3];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input string nm, input logic [511:0] blk, input int gaps);
        int rdy_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps != 0) begin
                repeat ($urandom_range(0, 2)) begin
                    msg_valid = 1'b0;
                    msg_word  = $urandom;
                    if (msg_ready !== 1'b1) rdy_bad++;
                    step();
                end
            end
            msg_valid = 1'b1;
            msg_word  = blk[511 - 32*i -: 32];
            if (msg_ready !== 1'b1) rdy_bad++;
            step();
        end
        msg_valid = 1'b0;
        chk({nm, ".load_ready"}, 256'(rdy_bad), 256'd0);
    endtask

    // Called in the cycle right after the 16th word was accepted.
    task automatic run_rounds(input string nm, input logic [511:0] blk,
                              input logic [255:0] exp, input int hold);
        int bad = 0;
        int hbad = 0;
        logic [31:0] exp_msg;
        msg_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            exp_msg = (k < 16) ? blk[511 - 32*k -: 32] : 32'd0;
            if (dp_init !== 1'b0 || busy !== 1'b1 || msg_ready !== 1'b0 ||
                digest_valid !== 1'b0 || dp_round_idx !== 6'(k) || dp_message !== exp_msg) bad++;
            msg_word = $urandom;
            step();
        end
        chk({nm, ".round_seq"}, 256'(bad), 256'd0);
        chk({nm, ".final_flags"}, 256'({dp_init, busy, digest_valid, msg_ready}), 256'(4'b1100));
        step();
        chk({nm, ".valid_rise"}, 256'({digest_valid, busy, msg_ready}), 256'(3'b100));
        chk({nm, ".digest"}, digest, exp);
        for (int j = 0; j < hold; j++) begin
            digest_ready = 1'b0;
            if (digest !== exp || digest_valid !== 1'b1 || msg_ready !== 1'b0) hbad++;
            msg_word = $urandom;
            step();
        end
        if (hold > 0) chk({nm, ".hold"}, 256'(hbad), 256'd0);
        msg_valid    = 1'b0;
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        chk({nm, ".after_out"}, 256'({digest_valid, msg_ready, busy}), 256'(3'b010));
        $display("[TB] hash %s digest %h", nm, digest);
    endtask

    task automatic wait_round(input string nm, input logic [5:0] r);
        int guard = 0;
        while (!(busy === 1'b1 && dp_init === 1'b0 && dp_round_idx === r) && guard < 200) begin
            step();
            guard++;
        end
        chk({nm, ".reach_round"}, 256'(guard < 200), 256'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vbad;
        vecs[0] = '{name: "abc",      blk: ABC_BLK,   exp: ABC_DIGEST,   gaps: 0, hold: 0};
        vecs[1] = '{name: "empty",    blk: EMPTY_BLK, exp: EMPTY_DIGEST, gaps: 0, hold: 3};
        vecs[2] = '{name: "abc_gaps", blk: ABC_BLK,   exp: ABC_DIGEST,   gaps: 1, hold: 10};

        reset_n      = 1'b0;
        clear        = 1'b0;
        msg_valid    = 1'b0;
        msg_word     = 32'd0;
        digest_ready = 1'b0;
        repeat (3) step();
        chk("reset.flags", 256'({msg_ready, dp_init, busy, digest_valid}), 256'(4'b1100));
        chk("reset.digest", digest, 256'd0);
        reset_n = 1'b1;
        step();
        chk("post_reset.flags", 256'({msg_ready, dp_init, busy, digest_valid, dp_round_idx}),
            256'({4'b1100, 6'd0}));

        for (int v = 0; v < 3; v++) begin
            load_block(vecs[v].name, vecs[v].blk, vecs[v].gaps);
            run_rounds(vecs[v].name, vecs[v].blk, vecs[v].exp, vecs[v].hold);
        end

        // Partial load, then clear with a word offered in the same cycle.
        for (int i = 0; i < 5; i++) begin
            msg_valid = 1'b1;
            msg_word  = $urandom;
            step();
        end
        clear = 1'b1;
        step();
        clear     = 1'b0;
        msg_valid = 1'b0;
        load_block("clr_load", ABC_BLK, 0);
        run_rounds("clr_load", ABC_BLK, ABC_DIGEST, 0);

        // Abort at round 30.
        load_block("clr_r30", ABC_BLK, 0);
        wait_round("clr_r30", 6'd30);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_r30.state", 256'({msg_ready, busy, dp_init, digest_valid, dp_round_idx}),
            256'({4'b1010, 6'd0}));
        vbad = 0;
        for (int i = 0; i < 80; i++) begin
            if (digest_valid !== 1'b0 || msg_ready !== 1'b1) vbad++;
            step();
        end
        chk("clr_r30.no_valid", 256'(vbad), 256'd0);
        load_block("abc_after_clr", ABC_BLK, 0);
        run_rounds("abc_after_clr", ABC_BLK, ABC_DIGEST, 0);

        // Asynchronous reset at round 40.
        load_block("rst_r40", EMPTY_BLK, 0);
        wait_round("rst_r40", 6'd40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_r40.flags", 256'({msg_ready, dp_init, busy, digest_valid, dp_round_idx}),
            256'({4'b1100, 6'd0}));
        chk("rst_r40.digest", digest, 256'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        load_block("empty_after_rst", EMPTY_BLK, 0);
        run_rounds("empty_after_rst", EMPTY_BLK, EMPTY_DIGEST, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
